// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave byte engine.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        LOAD,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_e;

    function automatic logic addr_match(input logic [I2C_ADDR_W-1:0] rx_addr,
                                        input logic [I2C_ADDR_W-1:0] own_addr);
        return rx_addr == own_addr;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Metastability chain for one I2C pin plus a history flop for 1-clk rise/fall events.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the idle bus level so leaving reset on an idle bus produces no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave_core.sv
// Byte-level I2C slave: START/STOP detection, address match, write delivery and
// read fetch over valid/ready, stretching SCL while no read byte is available.
module i2c_slave_core
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  scl_out,
    output logic                  sda_out,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk    (clk),
        .reset  (reset),
        .pin_in (scl_in),
        .level  (scl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk    (clk),
        .reset  (reset),
        .pin_in (sda_in),
        .level  (sda),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    // An SDA edge arriving with the SCL rise itself is our own stretch-release data
    // change, not a bus condition, so it is excluded from START/STOP.
    assign start_evt = sda_fall & scl & ~scl_rise;
    assign stop_evt  = sda_rise & scl & ~scl_rise;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
    logic                    done_q, done_d;
    logic                    rw_q, rw_d;
    logic [I2C_BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    tx_ready_q, tx_ready_d;
    logic                    sda_out_q, sda_out_d;
    logic                    scl_out_q, scl_out_d;
    logic                    busy_q, busy_d;
    logic [I2C_BYTE_W-1:0]   byte_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        done_d     = done_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = 1'b0;
        sda_out_d  = sda_out_q;
        scl_out_d  = scl_out_q;
        busy_d     = busy_q;
        byte_in    = {shift_q[I2C_BYTE_W-2:0], sda};

        if (start_evt) begin
            state_d   = ADDR;
            cnt_d     = 3'd0;
            done_d    = 1'b0;
            sda_out_d = 1'b1;
            scl_out_d = 1'b1;
        end else if (stop_evt) begin
            state_d   = IDLE;
            cnt_d     = 3'd0;
            done_d    = 1'b0;
            sda_out_d = 1'b1;
            scl_out_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                // done_q marks a complete byte waiting for the SCL fall that opens the ACK slot.
                ADDR: begin
                    if (scl_rise && !done_q) begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd7) begin
                            rw_d = sda;
                            if (addr_match(shift_q[I2C_ADDR_W-1:0], SLAVE_ADDR)) begin
                                busy_d = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (scl_fall && done_q) begin
                        sda_out_d = 1'b0;
                        done_d    = 1'b0;
                        state_d   = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d = LOAD;
                        end else begin
                            sda_out_d = 1'b1;
                            state_d   = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && !done_q) begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (scl_fall && done_q) begin
                        sda_out_d = 1'b0;
                        done_d    = 1'b0;
                        cnt_d     = 3'd0;
                        state_d   = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_out_d = 1'b1;
                        cnt_d     = 3'd0;
                        state_d   = WR_DATA;
                    end
                end
                LOAD: begin
                    if (tx_valid) begin
                        shift_d    = tx_data;
                        tx_ready_d = 1'b1;
                        sda_out_d  = tx_data[I2C_BYTE_W-1];
                        scl_out_d  = 1'b1;
                        cnt_d      = 3'd0;
                        state_d    = RD_DATA;
                    end else begin
                        scl_out_d = 1'b0;
                    end
                end
                // MSB is already on SDA from LOAD; each fall presents the next bit.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_out_d = 1'b1;
                            cnt_d     = 3'd0;
                            state_d   = RD_ACK;
                        end else begin
                            sda_out_d = shift_q[I2C_BYTE_W-2];
                            shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            cnt_d     = cnt_q + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && !done_q) begin
                        if (!sda) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d  = 1'b0;
                        state_d = LOAD;
                    end
                end
                IGNORE: begin
                    sda_out_d = 1'b1;
                    scl_out_d = 1'b1;
                    busy_d    = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            sda_out_q  <= 1'b1;
            scl_out_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            rw_q       <= rw_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            sda_out_q  <= sda_out_d;
            scl_out_q  <= scl_out_d;
            busy_q     <= busy_d;
        end
    end

    assign scl_out  = scl_out_q;
    assign sda_out  = sda_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-level I2C master on wired-AND pins.
module tb_i2c_slave_core;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_out, sda_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       scl_pin, sda_pin;

    int errors = 0;
    int checks = 0;

    int         rx_cnt = 0;
    int         tx_cnt = 0;
    int         sda_low_cnt = 0;
    logic       sda_prev = 1'b1;
    logic [7:0] rx_log [0:15];

    assign scl_pin = m_scl & scl_out;
    assign sda_pin = m_sda & sda_out;

    always #5 clk = ~clk;

    i2c_slave_core #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_pin),
        .sda_in   (sda_pin),
        .scl_out  (scl_out),
        .sda_out  (sda_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_log[rx_cnt[3:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_ready === 1'b1) tx_cnt <= tx_cnt + 1;
        if (sda_prev === 1'b1 && sda_out === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
        sda_prev <= sda_out;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_scl_high();
        int n;
        n = 0;
        while (scl_pin !== 1'b1 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (scl_pin !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL scl_release_timeout: scl=%b required 1", scl_pin);
        end
    endtask

    task automatic m_start();
        m_sda = 1'b1;
        tick(5);
        m_scl = 1'b1;
        wait_scl_high();
        tick(10);
        m_sda = 1'b0;
        tick(10);
        m_scl = 1'b0;
        tick(10);
    endtask

    task automatic m_stop();
        m_sda = 1'b0;
        tick(5);
        m_scl = 1'b1;
        wait_scl_high();
        tick(10);
        m_sda = 1'b1;
        tick(10);
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sda = b;
        tick(5);
        m_scl = 1'b1;
        wait_scl_high();
        tick(5);
        s = sda_pin;
        tick(5);
        m_scl = 1'b0;
        tick(10);
    endtask

    task automatic m_write(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(ack_bit, s);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(5);
        @(negedge clk);
        checks++; if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda_out: got %b want 1", sda_out); end
        checks++; if (scl_out !== 1'b1) begin errors++; $display("FAIL reset_scl_out: got %b want 1", scl_out); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        reset = 1'b0;
        tick(5);
    endtask

    task automatic test_write();
        logic ack;
        int   rx0, low0;
        rx0 = rx_cnt;
        low0 = sda_low_cnt;
        m_start();
        m_write(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_set: got %b want 1", busy); end
        m_write(8'h3C, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data1_ack: got %b want 0", ack); end
        m_write(8'hC3, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data2_ack: got %b want 0", ack); end
        m_stop();
        checks++; if (rx_cnt - rx0 !== 2) begin errors++; $display("FAIL wr_rx_count: got %0d want 2", rx_cnt - rx0); end
        checks++; if (rx_log[rx0[3:0]] !== 8'h3C) begin errors++; $display("FAIL wr_rx_byte0: got %h want 3c", rx_log[rx0[3:0]]); end
        checks++; if (rx_log[4'(rx0 + 1)] !== 8'hC3) begin errors++; $display("FAIL wr_rx_byte1: got %h want c3", rx_log[4'(rx0 + 1)]); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL wr_rx_data_hold: got %h want c3", rx_data); end
        checks++; if (sda_low_cnt - low0 !== 3) begin errors++; $display("FAIL wr_ack_lows: got %0d want 3", sda_low_cnt - low0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_clear: got %b want 0", busy); end
    endtask

    task automatic test_mismatch();
        logic ack;
        int   rx0, low0;
        rx0 = rx_cnt;
        low0 = sda_low_cnt;
        m_start();
        m_write(8'hA2, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_nack: got %b want 1", ack); end
        checks++; if (dut.state_q !== IGNORE) begin errors++; $display("FAIL mm_state: got %0d want IGNORE", dut.state_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b want 0", busy); end
        m_stop();
        checks++; if (sda_low_cnt - low0 !== 0) begin errors++; $display("FAIL mm_sda_low: got %0d want 0", sda_low_cnt - low0); end
        checks++; if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL mm_rx_count: got %0d want 0", rx_cnt - rx0); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        int         tx0;
        tx0 = tx_cnt;
        tx_data = 8'h96;
        tx_valid = 1'b1;
        m_start();
        m_write(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
        m_read(1'b0, d);
        checks++; if (d !== 8'h96) begin errors++; $display("FAIL rd_byte0: got %h want 96", d); end
        m_read(1'b1, d);
        checks++; if (d !== 8'h96) begin errors++; $display("FAIL rd_byte1: got %h want 96", d); end
        checks++; if (tx_cnt - tx0 !== 2) begin errors++; $display("FAIL rd_tx_ready_count: got %0d want 2", tx_cnt - tx0); end
        checks++; if (dut.state_q !== IGNORE) begin errors++; $display("FAIL rd_nack_state: got %0d want IGNORE", dut.state_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_nack_busy: got %b want 0", busy); end
        checks++; if (sda_out !== 1'b1) begin errors++; $display("FAIL rd_nack_sda: got %b want 1", sda_out); end
        tx_valid = 1'b0;
        m_stop();
    endtask

    task automatic test_stretch();
        logic       ack;
        logic [7:0] d;
        tx_valid = 1'b0;
        m_start();
        m_write(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL st_addr_ack: got %b want 0", ack); end
        fork
            m_read(1'b1, d);
            begin : slave_side
                int n;
                int highs;
                n = 0;
                highs = 0;
                while (scl_out !== 1'b0 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                checks++; if (scl_out !== 1'b0) begin errors++; $display("FAIL st_stretch_start: got %b want 0", scl_out); end
                repeat (50) begin
                    @(negedge clk);
                    if (scl_out !== 1'b0 || scl_pin !== 1'b0) highs++;
                end
                checks++; if (highs !== 0) begin errors++; $display("FAIL st_stretch_hold: got %0d releases want 0", highs); end
                @(posedge clk);
                #1;
                tx_data = 8'h5A;
                tx_valid = 1'b1;
                @(posedge clk);
                @(negedge clk);
                checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL st_tx_ready: got %b want 1", tx_ready); end
                checks++; if (scl_out !== 1'b1) begin errors++; $display("FAIL st_release: got %b want 1", scl_out); end
                checks++; if (sda_out !== 1'b0) begin errors++; $display("FAIL st_first_bit: got %b want 0", sda_out); end
                tx_valid = 1'b0;
            end
        join
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL st_byte: got %h want 5a", d); end
        m_stop();
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] d;
        int         rx0;
        rx0 = rx_cnt;
        m_start();
        m_write(8'hA0, ack);
        m_write(8'h11, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_wr_ack: got %b want 0", ack); end
        tx_data = 8'hE7;
        tx_valid = 1'b1;
        m_start();
        checks++; if (dut.state_q !== ADDR) begin errors++; $display("FAIL rs_state_addr: got %0d want ADDR", dut.state_q); end
        m_write(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_rd_addr_ack: got %b want 0", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b want 1", busy); end
        m_read(1'b1, d);
        checks++; if (d !== 8'hE7) begin errors++; $display("FAIL rs_rd_byte: got %h want e7", d); end
        checks++; if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL rs_rx_count: got %0d want 1", rx_cnt - rx0); end
        checks++; if (rx_log[rx0[3:0]] !== 8'h11) begin errors++; $display("FAIL rs_rx_byte: got %h want 11", rx_log[rx0[3:0]]); end
        tx_valid = 1'b0;
        m_stop();
    endtask

    task automatic test_abort();
        logic       ack;
        logic       s;
        int         rx0;
        rx0 = rx_cnt;
        m_start();
        m_write(8'hA0, ack);
        m_bit(1'b1, s);
        m_bit(1'b0, s);
        m_bit(1'b1, s);
        m_bit(1'b0, s);
        m_stop();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ab_stop_state: got %0d want IDLE", dut.state_q); end
        checks++; if (sda_out !== 1'b1 || scl_out !== 1'b1) begin errors++; $display("FAIL ab_stop_lines: got sda=%b scl=%b want 1 1", sda_out, scl_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_stop_busy: got %b want 0", busy); end
        checks++; if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL ab_stop_rx: got %0d want 0", rx_cnt - rx0); end

        tx_data = 8'h00;
        tx_valid = 1'b1;
        m_start();
        m_write(8'hA1, ack);
        m_bit(1'b1, s);
        m_bit(1'b1, s);
        m_bit(1'b1, s);
        checks++; if (dut.state_q !== RD_DATA) begin errors++; $display("FAIL ab_in_rd_data: got %0d want RD_DATA", dut.state_q); end
        checks++; if (sda_out !== 1'b0) begin errors++; $display("FAIL ab_rd_driving: got %b want 0", sda_out); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ab_reset_state: got %0d want IDLE", dut.state_q); end
        checks++; if (sda_out !== 1'b1 || scl_out !== 1'b1) begin errors++; $display("FAIL ab_reset_lines: got sda=%b scl=%b want 1 1", sda_out, scl_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_reset_busy: got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL ab_reset_pulses: got rx_valid=%b tx_ready=%b want 0 0", rx_valid, tx_ready); end
        tx_valid = 1'b0;
        reset = 1'b0;
        m_sda = 1'b1;
        tick(5);
        m_scl = 1'b1;
        tick(20);
        checks++; if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL ab_rx_total: got %0d want 0", rx_cnt - rx0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_stretch();
        test_repeated_start();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
